// File: rtl/instr_sequencer_fsm.sv
// instr_sequencer_fsm: multi-cycle fetch/decode/execute sequencer for the 4-bit core.
// Every output is a flop loaded from the next state, so strobes only ever move on a clk edge.
module instr_sequencer_fsm #(
   parameter int PC_WIDTH   = 4,
   parameter int LAST_ADDR  = 15,
   parameter int SETTLE_CYC = 1
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                run,
   input  logic [4:0]          instruction,
   output logic [PC_WIDTH-1:0] pc,
   output logic                oe_memo,
   output logic                oe_alu,
   output logic                oe_port,
   output logic                r_w,
   output logic                we_reg1,
   output logic                we_reg2,
   output logic                we_port,
   output logic                reg_sel,
   output logic [1:0]          alu_sel,
   output logic [1:0]          mem_addr,
   output logic                busy,
   output logic                halted
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WRITE, NEXT, HALT} state_t;
   state_t state, nxt;
   logic [4:0] ir, cur;
   logic [2:0] cnt, op;
   logic [1:0] a;
   logic src, wr, ld, in_op;

   always_comb begin
      cur = (state == DECODE) ? instruction : ir;
      op = cur[4:2];
      a = cur[1:0];
      nxt = state;
      case (state)
         IDLE:    nxt = run ? FETCH : IDLE;
         FETCH:   nxt = DECODE;
         DECODE:  nxt = (cur == 5'b11111) ? HALT : EXEC;
         EXEC:    nxt = (cnt == 3'(SETTLE_CYC - 1)) ? WRITE : EXEC;
         WRITE:   nxt = NEXT;
         NEXT:    nxt = run ? FETCH : IDLE;
         HALT:    nxt = HALT;
         default: nxt = IDLE;
      endcase
      src = (nxt == EXEC) || (nxt == WRITE);
      wr = nxt == WRITE;
      ld = !op[1];
      in_op = (op == 3'b111) && (a != 2'b11);
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         pc <= '0;
         ir <= '0;
         cnt <= '0;
         mem_addr <= '0;
         alu_sel <= '0;
         reg_sel <= 1'b0;
         oe_memo <= 1'b0;
         oe_alu <= 1'b0;
         oe_port <= 1'b0;
         r_w <= 1'b0;
         we_reg1 <= 1'b0;
         we_reg2 <= 1'b0;
         we_port <= 1'b0;
         busy <= 1'b0;
         halted <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= (state == EXEC && nxt == EXEC) ? cnt + 3'd1 : 3'd0;
         if (state == DECODE) begin
            ir <= instruction;
            mem_addr <= instruction[1:0];
            alu_sel <= instruction[1:0];
            // stores pick R1/R2 from opcode bit 0, OUT picks from operand bit 0
            reg_sel <= instruction[4] ? instruction[0] : instruction[2];
         end
         if (state == NEXT)
            pc <= (pc == PC_WIDTH'(LAST_ADDR)) ? '0 : pc + PC_WIDTH'(1);
         oe_memo <= src && (op[2:1] == 2'b00);
         oe_alu <= src && (op[2:1] == 2'b10);
         oe_port <= src && in_op;
         r_w <= wr && (op[2:1] == 2'b01);
         we_reg1 <= wr && ((ld && !op[0]) || (in_op && !a[0]));
         we_reg2 <= wr && ((ld && op[0]) || (in_op && a[0]));
         we_port <= wr && (op == 3'b110);
         busy <= (nxt != IDLE) && (nxt != HALT);
         halted <= nxt == HALT;
      end
   end
endmodule

// File: tb/tb_instr_sequencer_fsm.sv
// tb_instr_sequencer_fsm: table of instructions run as one program with a write-event scoreboard,
// plus directed sequences for timing, halt, async abort and a SETTLE_CYC=3 instance.
module tb_instr_sequencer_fsm;
   logic clk = 1'b0, clear = 1'b1, run = 1'b0;
   logic [4:0] instruction;
   logic [3:0] pc;
   logic oe_memo, oe_alu, oe_port, r_w, we_reg1, we_reg2, we_port, reg_sel, busy, halted;
   logic [1:0] alu_sel, mem_addr;
   logic clear3 = 1'b1, run3 = 1'b0;
   logic [4:0] instruction3 = 5'b10001;
   logic [3:0] pc3;
   logic oe_memo3, oe_alu3, oe_port3, r_w3, we_reg13, we_reg23, we_port3, reg_sel3, busy3, halted3;
   logic [1:0] alu_sel3, mem_addr3;
   logic [4:0] prog [16];

   typedef struct {logic [4:0] ins; logic [2:0] oe; logic [3:0] we; logic chk; logic sel;} vec_t;
   typedef struct packed {logic [2:0] oe; logic [3:0] we; logic [1:0] a; logic [3:0] pc; logic chk; logic sel;} exp_t;
   vec_t vecs [16];
   exp_t sbq [$];
   exp_t e;
   int tests = 0, fails = 0, viol = 0, cyc = 0, prev_wr = -1;
   logic mon_en = 1'b0;

   assign instruction = prog[pc];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_sequencer_fsm dut (
      .clk(clk), .clear(clear), .run(run), .instruction(instruction), .pc(pc),
      .oe_memo(oe_memo), .oe_alu(oe_alu), .oe_port(oe_port), .r_w(r_w),
      .we_reg1(we_reg1), .we_reg2(we_reg2), .we_port(we_port), .reg_sel(reg_sel),
      .alu_sel(alu_sel), .mem_addr(mem_addr), .busy(busy), .halted(halted)
   );

   instr_sequencer_fsm #(.SETTLE_CYC(3)) dut3 (
      .clk(clk), .clear(clear3), .run(run3), .instruction(instruction3), .pc(pc3),
      .oe_memo(oe_memo3), .oe_alu(oe_alu3), .oe_port(oe_port3), .r_w(r_w3),
      .we_reg1(we_reg13), .we_reg2(we_reg23), .we_port(we_port3), .reg_sel(reg_sel3),
      .alu_sel(alu_sel3), .mem_addr(mem_addr3), .busy(busy3), .halted(halted3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if ($countones({oe_memo, oe_alu, oe_port}) > 1 || ((oe_memo | oe_alu | oe_port) && !busy) ||
          $countones({r_w, we_reg1, we_reg2, we_port}) > 1 ||
          $countones({oe_memo3, oe_alu3, oe_port3}) > 1 || ((oe_memo3 | oe_alu3 | oe_port3) && !busy3) ||
          $countones({r_w3, we_reg13, we_reg23, we_port3}) > 1)
         viol++;
   end

   always @(negedge clk) begin
      if (mon_en && (r_w || we_reg1 || we_reg2 || we_port)) begin
         if (sbq.size() == 0) check("sb_underflow", 32'(sbq.size()), 32'd1);
         else begin
            e = sbq.pop_front();
            check("sb_write", 32'({oe_memo, oe_alu, oe_port, r_w, we_reg1, we_reg2, we_port, mem_addr, alu_sel, pc, e.chk & reg_sel}),
                  32'({e.oe, e.we, e.a, e.a, e.pc, e.chk & e.sel}));
         end
         if (prev_wr >= 0) check("period", 32'(cyc - prev_wr), 32'd5);
         prev_wr = cyc;
      end
   end

   initial begin
      logic [4:0] s_oe, s_we, s_busy;
      logic [2:0] s_halt, s_hbusy;
      logic [1:0] addr3;
      int bad, n, cnt_oe;
      int p [2];
      vecs[0]  = '{5'b00010, 3'b100, 4'b0100, 1'b0, 1'b0};
      vecs[1]  = '{5'b00101, 3'b100, 4'b0010, 1'b0, 1'b0};
      vecs[2]  = '{5'b01011, 3'b000, 4'b1000, 1'b1, 1'b0};
      vecs[3]  = '{5'b01101, 3'b000, 4'b1000, 1'b1, 1'b1};
      vecs[4]  = '{5'b10010, 3'b010, 4'b0100, 1'b0, 1'b0};
      vecs[5]  = '{5'b10101, 3'b010, 4'b0010, 1'b0, 1'b0};
      vecs[6]  = '{5'b11000, 3'b000, 4'b0001, 1'b1, 1'b0};
      vecs[7]  = '{5'b11001, 3'b000, 4'b0001, 1'b1, 1'b1};
      vecs[8]  = '{5'b11100, 3'b001, 4'b0100, 1'b0, 1'b0};
      vecs[9]  = '{5'b11101, 3'b001, 4'b0010, 1'b0, 1'b0};
      vecs[10] = '{5'b11110, 3'b001, 4'b0100, 1'b0, 1'b0};
      vecs[11] = '{5'b00011, 3'b100, 4'b0100, 1'b0, 1'b0};
      vecs[12] = '{5'b10000, 3'b010, 4'b0100, 1'b0, 1'b0};
      vecs[13] = '{5'b00110, 3'b100, 4'b0010, 1'b0, 1'b0};
      vecs[14] = '{5'b01110, 3'b000, 4'b1000, 1'b1, 1'b1};
      vecs[15] = '{5'b10011, 3'b010, 4'b0100, 1'b0, 1'b0};
      for (int i = 0; i < 16; i++) prog[i] = vecs[i].ins;
      repeat (3) @(negedge clk);
      clear = 1'b0;
      repeat (10) @(negedge clk);
      check("reset_pc", 32'(pc), 32'd0);
      check("reset_out", 32'({oe_memo, oe_alu, oe_port, r_w, we_reg1, we_reg2, we_port, reg_sel, alu_sel, mem_addr, busy, halted}), 32'd0);
      for (int i = 0; i < 16; i++)
         sbq.push_back('{vecs[i].oe, vecs[i].we, vecs[i].ins[1:0], 4'(i), vecs[i].chk, vecs[i].sel});
      sbq.push_back('{vecs[0].oe, vecs[0].we, vecs[0].ins[1:0], 4'd0, vecs[0].chk, vecs[0].sel});
      mon_en = 1'b1;
      run = 1'b1;
      s_oe = '0; s_we = '0; s_busy = '0; addr3 = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         s_oe = {s_oe[3:0], oe_memo};
         s_we = {s_we[3:0], we_reg1};
         s_busy = {s_busy[3:0], busy};
         if (k == 3) addr3 = mem_addr;
      end
      check("lda_oe_memo", 32'(s_oe), 32'b00110);
      check("lda_we_reg1", 32'(s_we), 32'b00010);
      check("lda_busy", 32'(s_busy), 32'b11111);
      check("lda_mem_addr", 32'(addr3), 32'd2);
      @(negedge clk);
      check("lda_pc", 32'(pc), 32'd1);
      for (int t = 0; t < 200 && sbq.size() > 1; t++) @(negedge clk);
      check("table_progress", 32'(sbq.size()), 32'd1);
      repeat (2) @(negedge clk);
      run = 1'b0;
      for (int t = 0; t < 50 && sbq.size() > 0; t++) @(negedge clk);
      check("sb_drain", 32'(sbq.size()), 32'd0);
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      check("idle_after_stop", 32'({busy, pc}), 32'({1'b0, 4'd1}));
      prog[1] = 5'b11111;
      run = 1'b1;
      s_halt = '0; s_hbusy = '0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         s_halt = {s_halt[1:0], halted};
         s_hbusy = {s_hbusy[1:0], busy};
      end
      check("halt_entry", 32'(s_halt), 32'b001);
      check("halt_busy", 32'(s_hbusy), 32'b110);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (pc != 4'd1 || busy || !halted || oe_memo || oe_alu || oe_port || r_w || we_reg1 || we_reg2 || we_port) bad++;
      end
      check("halt_frozen", 32'(bad), 32'd0);
      clear = 1'b1;
      #1 check("halt_clear", 32'({pc, halted, busy}), 32'd0);
      @(negedge clk);
      clear = 1'b0;
      run = 1'b0;
      @(negedge clk);
      check("clear_idle", 32'({busy, halted, pc}), 32'd0);
      prog[0] = 5'b00000;
      run = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_in_write", 32'({oe_memo, we_reg1}), 32'b11);
      #2 clear = 1'b1;
      #1 check("abort_strobes", 32'({oe_memo, oe_alu, oe_port, r_w, we_reg1, we_reg2, we_port, busy, pc}), 32'd0);
      @(negedge clk);
      clear = 1'b0;
      run = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_stays_idle", 32'({busy, pc}), 32'd0);
      clear3 = 1'b0;
      run3 = 1'b1;
      n = 0; cnt_oe = 0;
      for (int t = 0; t < 40 && n < 2; t++) begin
         @(negedge clk);
         if (n == 1 && oe_alu3) cnt_oe++;
         if (we_reg13) begin
            p[n] = cyc;
            n++;
         end
      end
      check("settle3_pulses", 32'(n), 32'd2);
      if (n == 2) check("settle3_period", 32'(p[1] - p[0]), 32'd7);
      check("settle3_oe_cycles", 32'(cnt_oe), 32'd4);
      check("settle3_alu_sel", 32'(alu_sel3), 32'd1);
      run3 = 1'b0;
      repeat (8) @(negedge clk);
      check("invariants", 32'(viol), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
